// File: rtl/reg_file_if.sv
// reg_file_if: command, data and SFR-forwarding signals between the PIC16C5x
// execute stage and the data register file.
//
// Command protocol (no handshake, no back-pressure): writeCommand is sampled
// on every rising clk edge. bit2 latches the operand address, bit1 commits the
// Q4 result, bit0 commits the ALU status flags. Each set bit acts at exactly
// that one edge. All read-side outputs are combinational from the current
// state and inputs. sfrWriteEnOut is a single-cycle strobe that is valid in
// the same cycle as the bit1 command that produces it.
interface reg_file_if;
    logic [2:0] writeCommand;
    logic [7:0] gprWriteDataIn;
    logic [7:0] statusWriteDataIn;
    logic [7:0] sfrReadDataIn;
    logic [7:0] gprReadDataOut;
    logic [7:0] gprStatusOut;
    logic [7:0] gprFSROut;
    logic [6:0] effAddrOut;
    logic       sfrWriteEnOut;
    logic [4:0] sfrAddrOut;
    logic [7:0] sfrWriteDataOut;

    modport master (
        output writeCommand, gprWriteDataIn, statusWriteDataIn, sfrReadDataIn,
        input  gprReadDataOut, gprStatusOut, gprFSROut, effAddrOut,
               sfrWriteEnOut, sfrAddrOut, sfrWriteDataOut
    );

    modport slave (
        input  writeCommand, gprWriteDataIn, statusWriteDataIn, sfrReadDataIn,
        output gprReadDataOut, gprStatusOut, gprFSROut, effAddrOut,
               sfrWriteEnOut, sfrAddrOut, sfrWriteDataOut
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: PIC16C5x data register file (STATUS, FSR, general-purpose RAM).
// Latches the operand address, resolves INDF through FSR, commits Q4 writes
// and status flags, and forwards unowned SFR accesses to an external block.
// Optional macro RF_BANKING_EN: PIC16C57-style banking, FSR[6:5] selects one
// of four 16-byte banks for addresses 0x10-0x1F (72 bytes of RAM in total).
module reg_file #(
    parameter logic [4:0] GPR_BASE = 5'h08
) (
    input logic      clk,
    input logic      rst_n,
    reg_file_if.slave bus
);

`ifdef RF_BANKING_EN
    localparam int SHARED    = 16 - int'(GPR_BASE);
    localparam int RAM_DEPTH = SHARED + 64;
    localparam int FSR_W     = 7;
`else
    localparam int RAM_DEPTH = 32 - int'(GPR_BASE);
    localparam int FSR_W     = 5;
`endif
    localparam int IDX_W = $clog2(RAM_DEPTH);

    logic [4:0]       addrLat;
    logic [7:0]       status;
    logic [7:0]       statusNext;
    logic [FSR_W-1:0] fsrReg;
    logic [7:0]       fsrFull;
    logic [7:0]       ram [RAM_DEPTH];

    logic [4:0]       effLow;
    logic [1:0]       bank;
    logic [IDX_W-1:0] ramIdx;
    logic             isNull, isStatus, isFsr, isRam, isSfr;
    logic             latchEn, q4Wr, stWr, q4Status;
    logic [7:0]       rdData;

    assign latchEn  = bus.writeCommand[2];
    assign q4Wr     = bus.writeCommand[1];
    assign stWr     = bus.writeCommand[0];
    assign q4Status = q4Wr && isStatus;

    // Unwritable FSR bits always read as 1.
`ifdef RF_BANKING_EN
    assign fsrFull = {1'b1, fsrReg};
`else
    assign fsrFull = {3'b111, fsrReg};
`endif

    // Effective address decode: INDF indirection, bank select, target class.
    always_comb begin
        effLow = (addrLat == 5'd0) ? fsrReg[4:0] : addrLat;
        bank   = 2'b00;
`ifdef RF_BANKING_EN
        if (effLow >= 5'h10) bank = fsrReg[6:5];
        if (effLow < 5'h10) ramIdx = IDX_W'(effLow - GPR_BASE);
        else                ramIdx = IDX_W'(SHARED + 16 * int'(bank) + int'(effLow[3:0]));
`else
        ramIdx = IDX_W'(effLow - GPR_BASE);
`endif
        isNull   = (effLow == 5'd0);
        isStatus = (effLow == 5'd3);
        isFsr    = (effLow == 5'd4);
        isRam    = (effLow >= GPR_BASE) && !isNull && !isStatus && !isFsr;
        isSfr    = !isNull && !isStatus && !isFsr && !isRam;
    end

    // Read mux back to the datapath.
    always_comb begin
        rdData = 8'h00;
        if (isStatus)   rdData = status;
        else if (isFsr) rdData = fsrFull;
        else if (isRam) rdData = ram[ramIdx];
        else if (isSfr) rdData = bus.sfrReadDataIn;
    end

    // STATUS merge: TO/PD are never written; a concurrent flag write owns [2:0].
    always_comb begin
        statusNext = status;
        if (stWr && q4Status)
            statusNext = (status & 8'h18) | (bus.gprWriteDataIn & 8'hE0)
                       | (bus.statusWriteDataIn & 8'h07);
        else if (stWr)
            statusNext = (status & 8'h18) | (bus.statusWriteDataIn & 8'hE7);
        else if (q4Status)
            statusNext = (status & 8'h18) | (bus.gprWriteDataIn & 8'hE7);
    end

    // Operand address latch (Q2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       addrLat <= 5'd0;
        else if (latchEn) addrLat <= bus.gprWriteDataIn[4:0];
    end

    // STATUS register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status <= 8'h18;
        else        status <= statusNext;
    end

    // FSR register (writable bits only).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             fsrReg <= '0;
        else if (q4Wr && isFsr) fsrReg <= bus.gprWriteDataIn[FSR_W-1:0];
    end

    // General-purpose RAM, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
        end else if (q4Wr && isRam) begin
            ram[ramIdx] <= bus.gprWriteDataIn;
        end
    end

    assign bus.gprReadDataOut  = rdData;
    assign bus.gprStatusOut    = status;
    assign bus.gprFSROut       = fsrFull;
    assign bus.effAddrOut      = {bank, effLow};
    assign bus.sfrWriteEnOut   = q4Wr && isSfr;
    assign bus.sfrAddrOut      = effLow;
    assign bus.sfrWriteDataOut = bus.gprWriteDataIn;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table plus hand-written reset and banking
// sequences for reg_file.
module tb_reg_file;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_if bus();

    reg_file #(.GPR_BASE(5'h08)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef RF_BANKING_EN
    localparam logic [7:0] FSR_HI = 8'h80;
`else
    localparam logic [7:0] FSR_HI = 8'hE0;
`endif

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] wd;
        logic [7:0] sd;
        logic [7:0] sf;
        logic [7:0] rd;
        logic [7:0] st;
        logic [7:0] fsr;
        logic [6:0] eff;
        logic       we;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic [2:0] cmd, input logic [7:0] wd, sd, sf,
                                input logic [7:0] rd, st, fsrLow,
                                input logic [6:0] eff, input logic we);
        vec_t v;
        v.cmd = cmd; v.wd = wd; v.sd = sd; v.sf = sf;
        v.rd = rd; v.st = st; v.fsr = FSR_HI | fsrLow; v.eff = eff; v.we = we;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] cmd, input logic [7:0] wd, sd, sf);
        @(negedge clk);
        bus.writeCommand      = cmd;
        bus.gprWriteDataIn    = wd;
        bus.statusWriteDataIn = sd;
        bus.sfrReadDataIn     = sf;
        #1;
    endtask

    // Scoreboard for forwarded SFR writes: each observed strobe pops one entry.
    task automatic sb_observe(input string name);
        logic [12:0] e;
        if (bus.sfrWriteEnOut === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, ".sfr"}, {3'b0, bus.sfrAddrOut, bus.sfrWriteDataOut}, {3'b0, e});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.writeCommand = 3'b000; bus.gprWriteDataIn = 8'h00;
        bus.statusWriteDataIn = 8'h00; bus.sfrReadDataIn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.status", {8'h0, bus.gprStatusOut}, 16'h0018);
        chk("rst.fsr", {8'h0, bus.gprFSROut}, {8'h0, FSR_HI});
        chk("rst.eff", {9'h0, bus.effAddrOut}, 16'h0000);
        chk("rst.sfrwe", {15'h0, bus.sfrWriteEnOut}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        //                cmd   wd     sd     sf     rd              st     fsrLo  eff    we
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h00, 1'b0));
        vecs.push_back(mk(3'd4, 8'h08, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h00, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h08, 1'b0));
        vecs.push_back(mk(3'd4, 8'h0A, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h08, 1'b0));
        vecs.push_back(mk(3'd2, 8'h5A, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h5A,          8'h18, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd4, 8'h0B, 8'h00, 8'h00, 8'h5A,          8'h18, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h0B, 1'b0));
        vecs.push_back(mk(3'd4, 8'h04, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h0B, 1'b0));
        vecs.push_back(mk(3'd2, 8'h0C, 8'h00, 8'h00, FSR_HI,         8'h18, 8'h00, 7'h04, 1'b0));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, FSR_HI | 8'h0C, 8'h18, 8'h0C, 7'h04, 1'b0));
        vecs.push_back(mk(3'd2, 8'hA5, 8'h00, 8'h00, 8'h00,          8'h18, 8'h0C, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h0C, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd4, 8'h0C, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h0C, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h0C, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd4, 8'h04, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h0C, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, FSR_HI | 8'h0C, 8'h18, 8'h0C, 7'h04, 1'b0));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, FSR_HI,         8'h18, 8'h00, 7'h04, 1'b0));
        vecs.push_back(mk(3'd2, 8'h77, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h00, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h00, 1'b0));
        vecs.push_back(mk(3'd4, 8'h0C, 8'h00, 8'h00, 8'h00,          8'h18, 8'h00, 7'h00, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h00, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd4, 8'h03, 8'h00, 8'h00, 8'hA5,          8'h18, 8'h00, 7'h0C, 1'b0));
        vecs.push_back(mk(3'd3, 8'hFF, 8'h04, 8'h00, 8'h18,          8'h18, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hFC,          8'hFC, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd1, 8'h00, 8'h00, 8'h00, 8'hFC,          8'hFC, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h18,          8'h18, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd2, 8'h07, 8'h00, 8'h00, 8'h18,          8'h18, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h1F,          8'h1F, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd1, 8'h00, 8'hFF, 8'h00, 8'h1F,          8'h1F, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hFF,          8'hFF, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd4, 8'h06, 8'h00, 8'h00, 8'hFF,          8'hFF, 8'h00, 7'h03, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h9C, 8'h9C,          8'hFF, 8'h00, 7'h06, 1'b0));
        vecs.push_back(mk(3'd2, 8'h3C, 8'h00, 8'h9C, 8'h9C,          8'hFF, 8'h00, 7'h06, 1'b1));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h9C, 8'h9C,          8'hFF, 8'h00, 7'h06, 1'b0));
        vecs.push_back(mk(3'd6, 8'h0A, 8'h00, 8'h9C, 8'h9C,          8'hFF, 8'h00, 7'h06, 1'b1));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h5A,          8'hFF, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd6, 8'h0B, 8'h00, 8'h00, 8'h5A,          8'hFF, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd4, 8'h0A, 8'h00, 8'h00, 8'h00,          8'hFF, 8'h00, 7'h0B, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h0B,          8'hFF, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd4, 8'h1F, 8'h00, 8'h00, 8'h0B,          8'hFF, 8'h00, 7'h0A, 1'b0));
        vecs.push_back(mk(3'd2, 8'hC3, 8'h00, 8'h00, 8'h00,          8'hFF, 8'h00, 7'h1F, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'hC3,          8'hFF, 8'h00, 7'h1F, 1'b0));
        vecs.push_back(mk(3'd4, 8'h08, 8'h00, 8'h00, 8'hC3,          8'hFF, 8'h00, 7'h1F, 1'b0));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00,          8'hFF, 8'h00, 7'h08, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            step(vecs[i].cmd, vecs[i].wd, vecs[i].sd, vecs[i].sf);
            if (vecs[i].we) exp_q.push_back({vecs[i].eff[4:0], vecs[i].wd});
            chk({nm, ".rd"},  {8'h0, bus.gprReadDataOut}, {8'h0, vecs[i].rd});
            chk({nm, ".st"},  {8'h0, bus.gprStatusOut},   {8'h0, vecs[i].st});
            chk({nm, ".fsr"}, {8'h0, bus.gprFSROut},      {8'h0, vecs[i].fsr});
            chk({nm, ".eff"}, {9'h0, bus.effAddrOut},     {9'h0, vecs[i].eff});
            chk({nm, ".we"},  {15'h0, bus.sfrWriteEnOut}, {15'h0, vecs[i].we});
            sb_observe(nm);
        end
        chk("sfr.queue_empty", 16'(exp_q.size()), 16'h0000);

        // Reset in the middle of an instruction: latch 0x0A, then reset with a
        // Q4 write pending. The write must be lost and RAM cleared.
        step(3'd4, 8'h0A, 8'h00, 8'h00);
        @(negedge clk);
        bus.writeCommand = 3'd2; bus.gprWriteDataIn = 8'h99;
        rst_n = 1'b0;
        #1;
        chk("midrst.eff",   {9'h0, bus.effAddrOut},     16'h0000);
        chk("midrst.st",    {8'h0, bus.gprStatusOut},   16'h0018);
        chk("midrst.fsr",   {8'h0, bus.gprFSROut},      {8'h0, FSR_HI});
        chk("midrst.we",    {15'h0, bus.sfrWriteEnOut}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.writeCommand = 3'd0; bus.gprWriteDataIn = 8'h00;
        #1;
        chk("postrst.rd",   {8'h0, bus.gprReadDataOut}, 16'h0000);
        step(3'd4, 8'h0A, 8'h00, 8'h00);
        step(3'd0, 8'h00, 8'h00, 8'h00);
        chk("postrst.eff",  {9'h0, bus.effAddrOut},     16'h000A);
        chk("postrst.ram0A", {8'h0, bus.gprReadDataOut}, 16'h0000);
        step(3'd4, 8'h1F, 8'h00, 8'h00);
        step(3'd0, 8'h00, 8'h00, 8'h00);
        chk("postrst.ram1F", {8'h0, bus.gprReadDataOut}, 16'h0000);

`ifdef RF_BANKING_EN
        // Banked RAM: bank 1 and bank 2 hold independent 0x10 bytes.
        step(3'd4, 8'h04, 8'h00, 8'h00);
        step(3'd2, 8'h20, 8'h00, 8'h00);
        step(3'd4, 8'h10, 8'h00, 8'h00);
        step(3'd2, 8'h11, 8'h00, 8'h00);
        chk("bank.eff1",   {9'h0, bus.effAddrOut},     16'h0030);
        step(3'd4, 8'h04, 8'h00, 8'h00);
        step(3'd2, 8'h40, 8'h00, 8'h00);
        step(3'd4, 8'h10, 8'h00, 8'h00);
        step(3'd0, 8'h00, 8'h00, 8'h00);
        chk("bank.eff2",   {9'h0, bus.effAddrOut},     16'h0050);
        chk("bank.rd2",    {8'h0, bus.gprReadDataOut}, 16'h0000);
        step(3'd4, 8'h04, 8'h00, 8'h00);
        step(3'd2, 8'h20, 8'h00, 8'h00);
        step(3'd4, 8'h10, 8'h00, 8'h00);
        step(3'd0, 8'h00, 8'h00, 8'h00);
        chk("bank.rd1",    {8'h0, bus.gprReadDataOut}, 16'h0011);
        chk("bank.fsr",    {8'h0, bus.gprFSROut},      16'h00A0);
        step(3'd4, 8'h08, 8'h00, 8'h00);
        step(3'd0, 8'h00, 8'h00, 8'h00);
        chk("bank.shared", {9'h0, bus.effAddrOut},     16'h0008);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
